// File: rtl/pi_loop_seq_pkg.sv
// pi_loop_seq_pkg: shared state encoding and saturation limit helpers for the
// PI loop sequencer and its saturation watcher.
package pi_loop_seq_pkg;

    // Encoding is visible on the state output: 0 IDLE, 1 RAMP, 2 LOCK, 3 TRIP.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRamp = 2'd1,
        StLock = 2'd2,
        StTrip = 2'd3
    } seq_state_e;

    // Largest positive value of a signed word of width dw.
    function automatic int sat_pos_max(input int unsigned dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    // Most negative value of a signed word of width dw.
    function automatic int sat_neg_max(input int unsigned dw);
        return -(1 << (dw - 1));
    endfunction

endpackage

// File: rtl/pi_sat_watch.sv
// pi_sat_watch: counts consecutive saturated PI X outputs while the loop is
// closing or closed and requests a trip when the count reaches the limit.
// Only built when PI_LOOP_SEQ_SATTRIP_EN is defined.
`ifdef PI_LOOP_SEQ_SATTRIP_EN
module pi_sat_watch
    import pi_loop_seq_pkg::*;
#(
    parameter int unsigned DW = 18,
    parameter int unsigned SW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_active,
    input  logic          i_tick,
    input  logic [DW-1:0] i_pi_out_d,
    input  logic [SW-1:0] i_sat_limit,
    output logic          o_trip_req
);

    localparam logic [DW-1:0] PosMax = DW'(sat_pos_max(DW));
    localparam logic [DW-1:0] NegMax = DW'(sat_neg_max(DW));

    logic [SW-1:0] r_cnt;
    logic [SW-1:0] w_cnt_next;
    logic          w_sat;

    assign w_sat = (i_pi_out_d == PosMax) || (i_pi_out_d == NegMax);

    // Count sticks at all-ones rather than wrapping back to a small value.
    assign w_cnt_next = w_sat ? ((&r_cnt) ? r_cnt : r_cnt + SW'(1)) : '0;

    // Combinational so the sequencer can act on the same tick edge.
    assign o_trip_req = i_active && i_tick && w_sat && (i_sat_limit != '0) &&
                        (w_cnt_next == i_sat_limit);

    // Consecutive-saturation counter; forced to zero outside RAMP/LOCK.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_active) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            r_cnt <= w_cnt_next;
        end
    end

endmodule
`endif

// File: rtl/pi_loop_seq.sv
// pi_loop_seq: brings the X/Y PI loop from open loop to closed loop. Holds the
// integrator cleared in IDLE, ramps the X setpoint to target one step per PI
// update, then locks. With PI_LOOP_SEQ_SATTRIP_EN defined, sustained output
// saturation trips the loop back to the zeroed state; otherwise TRIP is
// unreachable and tripped stays low.
module pi_loop_seq
    import pi_loop_seq_pkg::*;
#(
    parameter int unsigned DW = 18,
    parameter int unsigned SW = 16  // must be narrower than DW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [DW-1:0] x_target,
    input  logic [DW-1:0] y_target,
    input  logic [SW-1:0] ramp_step,
    input  logic [SW-1:0] sat_limit,
    input  logic [DW-1:0] pi_out_d,
    input  logic          pi_out_strobe,
    output logic          zerome,
    output logic [DW-1:0] x_set,
    output logic [DW-1:0] y_set,
    output logic [1:0]    state,
    output logic          tripped,
    output logic          locked
);

    seq_state_e    r_state;
    logic          r_zerome;
    logic          r_tripped;
    logic          r_locked;
    logic [DW-1:0] r_x_set;
    logic [DW-1:0] r_y_set;

    logic [DW:0]   w_diff;
    logic [DW:0]   w_mag;
    logic [DW:0]   w_step_ext;
    logic [DW-1:0] w_x_step;
    logic          w_diff_neg;
    logic          w_jump;
    logic          w_active;
    logic          w_trip;

    assign w_active = (r_state == StRamp) || (r_state == StLock);

    // Difference taken one bit wider so it can never overflow.
    assign w_diff     = {x_target[DW-1], x_target} - {r_x_set[DW-1], r_x_set};
    assign w_diff_neg = w_diff[DW];
    assign w_mag      = w_diff_neg ? -w_diff : w_diff;
    assign w_step_ext = {{(DW + 1 - SW){1'b0}}, ramp_step};
    assign w_jump     = (ramp_step == '0) || (w_mag <= w_step_ext);

    // Only used when |d| > step, so the result lies strictly between x_set
    // and x_target: no overshoot and no wrap.
    assign w_x_step = w_diff_neg ? (r_x_set - DW'(ramp_step)) : (r_x_set + DW'(ramp_step));

`ifdef PI_LOOP_SEQ_SATTRIP_EN
    pi_sat_watch #(
        .DW(DW),
        .SW(SW)
    ) u_sat_watch (
        .clk        (clk),
        .rst        (rst),
        .i_active   (w_active),
        .i_tick     (pi_out_strobe),
        .i_pi_out_d (pi_out_d),
        .i_sat_limit(sat_limit),
        .o_trip_req (w_trip)
    );
`else
    logic w_unused_sat;
    assign w_unused_sat = ^{sat_limit, pi_out_d};
    assign w_trip       = 1'b0;
`endif

    // Sequencer FSM with registered outputs; run=0 beats trip beats ramp/lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_zerome  <= 1'b1;
            r_tripped <= 1'b0;
            r_locked  <= 1'b0;
            r_x_set   <= '0;
            r_y_set   <= '0;
        end else begin
            r_y_set <= y_target;
            case (r_state)
                StIdle: begin
                    r_zerome <= 1'b1;
                    r_x_set  <= '0;
                    if (run) begin
                        r_state  <= StRamp;
                        r_zerome <= 1'b0;
                    end
                end
                StRamp: begin
                    if (!run) begin
                        r_state  <= StIdle;
                        r_zerome <= 1'b1;
                        r_x_set  <= '0;
                    end else if (w_trip) begin
                        r_state   <= StTrip;
                        r_zerome  <= 1'b1;
                        r_tripped <= 1'b1;
                    end else if (pi_out_strobe) begin
                        if (w_jump) begin
                            r_x_set  <= x_target;
                            r_state  <= StLock;
                            r_locked <= 1'b1;
                        end else begin
                            r_x_set <= w_x_step;
                        end
                    end
                end
                StLock: begin
                    if (!run) begin
                        r_state  <= StIdle;
                        r_zerome <= 1'b1;
                        r_locked <= 1'b0;
                        r_x_set  <= '0;
                    end else if (w_trip) begin
                        r_state   <= StTrip;
                        r_zerome  <= 1'b1;
                        r_locked  <= 1'b0;
                        r_tripped <= 1'b1;
                    end else if (pi_out_strobe && (x_target != r_x_set)) begin
                        // Re-enter RAMP without stepping on this tick.
                        r_state  <= StRamp;
                        r_locked <= 1'b0;
                    end
                end
                StTrip: begin
                    if (!run) begin
                        r_state   <= StIdle;
                        r_tripped <= 1'b0;
                        r_x_set   <= '0;
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    r_zerome  <= 1'b1;
                    r_tripped <= 1'b0;
                    r_locked  <= 1'b0;
                    r_x_set   <= '0;
                end
            endcase
        end
    end

    assign zerome  = r_zerome;
    assign x_set   = r_x_set;
    assign y_set   = r_y_set;
    assign state   = r_state;
    assign tripped = r_tripped;
    assign locked  = r_locked;

endmodule

// File: tb/tb_pi_loop_seq.sv
// tb_pi_loop_seq: table vectors, directed corner sequences and randomized
// stimulus checked against an arithmetic reference model of the sequencer.
module tb_pi_loop_seq;

    localparam int DW   = 18;
    localparam int SW   = 16;
    localparam int PMAX = 131071;
    localparam int NMAX = -131072;
`ifdef PI_LOOP_SEQ_SATTRIP_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [DW-1:0] x_target;
    logic [DW-1:0] y_target;
    logic [SW-1:0] ramp_step;
    logic [SW-1:0] sat_limit;
    logic [DW-1:0] pi_out_d;
    logic          pi_out_strobe;
    logic          zerome;
    logic [DW-1:0] x_set;
    logic [DW-1:0] y_set;
    logic [1:0]    state;
    logic          tripped;
    logic          locked;

    always #5 clk = ~clk;

    pi_loop_seq #(
        .DW(DW),
        .SW(SW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .x_target     (x_target),
        .y_target     (y_target),
        .ramp_step    (ramp_step),
        .sat_limit    (sat_limit),
        .pi_out_d     (pi_out_d),
        .pi_out_strobe(pi_out_strobe),
        .zerome       (zerome),
        .x_set        (x_set),
        .y_set        (y_set),
        .state        (state),
        .tripped      (tripped),
        .locked       (locked)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: state as 0..3, setpoints and count as plain integers.
    int m_state = 0;
    int m_x     = 0;
    int m_y     = 0;
    int m_cnt   = 0;

    typedef struct {
        bit run;
        int tgt;
        int step;
        bit strobe;
        int exp_state;
        int exp_x;
        bit exp_locked;
    } vec_t;

    vec_t vecs[13];

    function automatic int sx(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_update();
        int  tgt;
        int  d;
        int  mag;
        bit  sat;
        bit  trip;
        tgt = sx(x_target);
        if (rst) begin
            m_state = 0;
            m_x     = 0;
            m_y     = 0;
            m_cnt   = 0;
            return;
        end
        m_y = sx(y_target);
        if (m_state == 0 || m_state == 3) m_cnt = 0;
        if (m_state == 0) begin
            if (run) m_state = 1;
        end else if (m_state == 3) begin
            if (!run) begin
                m_state = 0;
                m_x     = 0;
            end
        end else if (!run) begin
            m_state = 0;
            m_x     = 0;
        end else if (pi_out_strobe) begin
            sat   = (sx(pi_out_d) == PMAX) || (sx(pi_out_d) == NMAX);
            m_cnt = sat ? ((m_cnt < 65535) ? m_cnt + 1 : m_cnt) : 0;
            trip  = SatEn && sat && (sat_limit != 0) && (m_cnt == int'(sat_limit));
            if (trip) begin
                m_state = 3;
            end else if (m_state == 1) begin
                d   = tgt - m_x;
                mag = (d < 0) ? -d : d;
                if (ramp_step == 0 || mag <= int'(ramp_step)) begin
                    m_x     = tgt;
                    m_state = 2;
                end else begin
                    m_x = m_x + ((d > 0) ? int'(ramp_step) : -int'(ramp_step));
                end
            end else if (tgt != m_x) begin
                m_state = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("state", int'(state), m_state);
        check("x_set", sx(x_set), m_x);
        check("y_set", sx(y_set), m_y);
        check("zerome", int'(zerome), int'(m_state == 0 || m_state == 3));
        check("locked", int'(locked), int'(m_state == 2));
        check("tripped", int'(tripped), int'(m_state == 3));
    endtask

    initial begin
        // run, target, step, strobe -> state, x_set, locked
        vecs[0]  = '{1'b1, 1000, 300, 1'b0, 1, 0, 1'b0};
        vecs[1]  = '{1'b1, 1000, 300, 1'b1, 1, 300, 1'b0};
        vecs[2]  = '{1'b1, 1000, 300, 1'b1, 1, 600, 1'b0};
        vecs[3]  = '{1'b1, 1000, 300, 1'b0, 1, 600, 1'b0};
        vecs[4]  = '{1'b1, 1000, 300, 1'b1, 1, 900, 1'b0};
        vecs[5]  = '{1'b1, 1000, 300, 1'b1, 2, 1000, 1'b1};
        vecs[6]  = '{1'b0, 1000, 300, 1'b0, 0, 0, 1'b0};
        vecs[7]  = '{1'b1, -500, 0, 1'b0, 1, 0, 1'b0};
        vecs[8]  = '{1'b1, -500, 0, 1'b1, 2, -500, 1'b1};
        vecs[9]  = '{1'b1, -400, 0, 1'b0, 2, -500, 1'b1};
        vecs[10] = '{1'b1, -400, 0, 1'b1, 1, -500, 1'b0};
        vecs[11] = '{1'b1, -400, 0, 1'b1, 2, -400, 1'b1};
        vecs[12] = '{1'b1, -400, 0, 1'b1, 2, -400, 1'b1};

        rst           = 1'b1;
        run           = 1'b0;
        x_target      = '0;
        y_target      = '0;
        ramp_step     = '0;
        sat_limit     = '0;
        pi_out_d      = '0;
        pi_out_strobe = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Idle with run low: loop stays zeroed even with ticks present.
        pi_out_strobe = 1'b1;
        for (int i = 0; i < 20; i++) begin
            y_target = DW'(i * 7 - 50);
            step();
            check("idle_zerome", int'(zerome), 1);
            check("idle_x_set", sx(x_set), 0);
            check("idle_state", int'(state), 0);
        end
        pi_out_strobe = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run           = vecs[i].run;
            x_target      = DW'(vecs[i].tgt);
            ramp_step     = SW'(vecs[i].step);
            pi_out_strobe = vecs[i].strobe;
            step();
            check($sformatf("tbl%0d_state", i), int'(state), vecs[i].exp_state);
            check($sformatf("tbl%0d_x_set", i), sx(x_set), vecs[i].exp_x);
            check($sformatf("tbl%0d_locked", i), int'(locked), int'(vecs[i].exp_locked));
        end
        run           = 1'b0;
        pi_out_strobe = 1'b0;
        step();

        // Reset in the middle of a ramp discards the partial setpoint.
        run       = 1'b1;
        x_target  = DW'(1000);
        ramp_step = SW'(300);
        step();
        pi_out_strobe = 1'b1;
        step();
        step();
        check("mid_ramp_x_set", sx(x_set), 600);
        rst           = 1'b1;
        pi_out_strobe = 1'b0;
        step();
        check("rst_x_set", sx(x_set), 0);
        check("rst_zerome", int'(zerome), 1);
        check("rst_state", int'(state), 0);
        rst = 1'b0;
        run = 1'b0;
        step();

        // Saturation: two saturated, one clean, then three saturated ticks.
        run       = 1'b1;
        x_target  = DW'(100);
        ramp_step = '0;
        sat_limit = SW'(3);
        step();
        pi_out_strobe = 1'b1;
        step();
        pi_out_d = DW'(PMAX);
        step();
        step();
        pi_out_d = DW'(5);
        step();
        pi_out_d = DW'(PMAX);
        step();
        step();
        check("sat_pre_trip_state", int'(state), 2);
        step();
        check("sat_tripped", int'(tripped), int'(SatEn));
        check("sat_zerome", int'(zerome), int'(SatEn));
        check("sat_state", int'(state), SatEn ? 3 : 2);
        check("sat_x_hold", sx(x_set), 100);
        pi_out_strobe = 1'b0;
        pi_out_d      = '0;
        run           = 1'b0;
        step();
        check("trip_exit_state", int'(state), 0);
        check("trip_exit_x_set", sx(x_set), 0);

        // Limit 1 with negative saturation on every tick.
        run       = 1'b1;
        x_target  = DW'(1000);
        ramp_step = SW'(300);
        sat_limit = SW'(1);
        pi_out_d  = DW'(NMAX);
        step();
        pi_out_strobe = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("neg_sat_state", int'(state), SatEn ? 3 : 2);
        check("neg_sat_x_set", sx(x_set), SatEn ? 0 : 1000);
        check("neg_sat_tripped", int'(tripped), int'(SatEn));
        run           = 1'b0;
        pi_out_strobe = 1'b0;
        pi_out_d      = '0;
        sat_limit     = '0;
        step();

        // Randomized traffic against the model.
        run = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            int r;
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) run = !run;
            pi_out_strobe = ($urandom_range(0, 2) == 0);
            y_target      = DW'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0: x_target = DW'(PMAX);
                    1: x_target = DW'(NMAX);
                    2: x_target = DW'($urandom);
                    default: begin
                        r        = int'($urandom_range(0, 4000));
                        x_target = DW'(r - 2000);
                    end
                endcase
            end
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 2))
                    0: ramp_step = '0;
                    1: ramp_step = SW'($urandom_range(1, 500));
                    default: ramp_step = SW'($urandom);
                endcase
            end
            case ($urandom_range(0, 3))
                0: pi_out_d = DW'(PMAX);
                1: pi_out_d = DW'(NMAX);
                default: pi_out_d = DW'($urandom);
            endcase
            if ($urandom_range(0, 99) == 0) sat_limit = SW'($urandom_range(0, 4));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
